// File: rtl/pattern_loader.sv
// rtl/pattern_loader.sv - byte-stream to serial loader for the pattern buffer; optional readback via PATTERN_LOADER_READBACK_EN
module pattern_loader #(
    parameter int buffer_width = 8,
    parameter int buffer_size  = 32,
    parameter int count_width  = 5
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [buffer_width-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    ssel,
    output logic                    sin,
    input  logic                    sout,
`ifdef PATTERN_LOADER_READBACK_EN
    output logic [buffer_width-1:0] rd_data,
    output logic                    rd_valid,
`endif
    output logic [count_width:0]    bytes_sent
);

    localparam int bit_cw = $clog2(buffer_width);
    localparam logic [bit_cw-1:0]    last_bit  = bit_cw'(buffer_width - 1);
    localparam logic [bit_cw-1:0]    pre_last  = bit_cw'(buffer_width - 2);
    localparam logic [count_width:0] last_byte = (count_width + 1)'(buffer_size - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT
    } state_t;

    state_t                  state;
    logic [buffer_width-2:0] pending;
    logic [bit_cw-1:0]       bit_cnt;
    logic                    accept;

    assign accept = in_valid & in_ready;
    assign busy   = (state != IDLE);

    // pending holds the bits still to be driven on sin; its top bit is the next one out
    always_ff @(posedge sclk) begin
        done <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            ssel       <= 1'b0;
            sin        <= 1'b0;
            bytes_sent <= '0;
            pending    <= '0;
            bit_cnt    <= '0;
        end else if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            ssel     <= 1'b0;
            sin      <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT_BYTE;
                        in_ready   <= 1'b1;
                        bytes_sent <= '0;
                    end
                end
                WAIT_BYTE: begin
                    if (accept) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        ssel     <= 1'b1;
                        sin      <= in_data[buffer_width-1];
                        pending  <= in_data[buffer_width-2:0];
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == last_bit) begin
                        bytes_sent <= bytes_sent + 1'b1;
                        in_ready   <= 1'b0;
                        if (bytes_sent == last_byte) begin
                            state <= IDLE;
                            ssel  <= 1'b0;
                            sin   <= 1'b0;
                            done  <= 1'b1;
                        end else if (accept) begin
                            ssel    <= 1'b1;
                            sin     <= in_data[buffer_width-1];
                            pending <= in_data[buffer_width-2:0];
                            bit_cnt <= '0;
                        end else begin
                            state    <= WAIT_BYTE;
                            in_ready <= 1'b1;
                            ssel     <= 1'b0;
                            sin      <= 1'b0;
                        end
                    end else begin
                        sin     <= pending[buffer_width-2];
                        pending <= {pending[buffer_width-3:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        // open the next-byte window during the final bit period
                        if (bit_cnt == pre_last) begin
                            in_ready <= (bytes_sent != last_byte);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PATTERN_LOADER_READBACK_EN
    logic [buffer_width-2:0] rd_shreg;

    // sout is the old bit leaving the buffer on the same edge sin enters it
    always_ff @(posedge sclk) begin
        rd_valid <= 1'b0;
        if (rst) begin
            rd_shreg <= '0;
            rd_data  <= '0;
        end else if (abort) begin
            rd_shreg <= '0;
        end else if (state == SHIFT) begin
            rd_shreg <= {rd_shreg[buffer_width-3:0], sout};
            if (bit_cnt == last_bit) begin
                rd_data  <= {rd_shreg, sout};
                rd_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_sout;
    assign unused_sout = sout;
`endif

endmodule
